// File: rtl/sd_otf_converter.sv
// Converts an MSD-first radix-2 signed-digit stream to two's complement using Q/QM on-the-fly registers; result_valid comes online_delay+unrolling cycles after start.
// The stream is free-running and there is no backpressure. Define OTF_QM_OUT_EN to expose QM on result_qm.
module sd_otf_converter #(
  parameter int unrolling    = 64,
  parameter int online_delay = 3,
  parameter int CNT_WIDTH    = 11
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic                 enable_all,
  input  logic [1:0]           q_value,
  output logic [unrolling:0]   result,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 digit_err
`ifdef OTF_QM_OUT_EN
  ,
  output logic [unrolling:0]   result_qm
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SKIP    = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Cycle indices, relative to the start cycle, of the last skip and last collect cycles.
  localparam logic [CNT_WIDTH-1:0] LAST_SKIP = CNT_WIDTH'(online_delay - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_COLL = CNT_WIDTH'(online_delay + unrolling - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_en_prev;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cyc;
  logic [unrolling:0]     r_q;
  logic [unrolling:0]     r_qm;
  logic [unrolling:0]     r_result;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_err;
  logic                   w_start;
  logic                   w_collect;
  logic                   w_plus;
  logic                   w_minus;
  logic                   w_inv;
  logic [unrolling:0]     w_q_base;
  logic [unrolling:0]     w_qm_base;
  logic [unrolling:0]     w_q_upd;
  logic [unrolling:0]     w_qm_upd;

  assign w_start = (r_state == S_IDLE) && enable_all && !r_en_prev;
  assign w_cyc   = r_cnt + CNT_WIDTH'(1);

  assign w_plus  = (q_value == 2'b10);
  assign w_minus = (q_value == 2'b01);
  assign w_inv   = (q_value == 2'b11);

  // On the start cycle the conversion begins from Q = 0, QM = -1.
  assign w_q_base  = w_start ? '0 : r_q;
  assign w_qm_base = w_start ? '1 : r_qm;

  always_comb begin
    w_q_upd  = {w_q_base[unrolling-1:0], 1'b0};
    w_qm_upd = {w_qm_base[unrolling-1:0], 1'b1};
    if (w_plus) begin
      w_q_upd  = {w_q_base[unrolling-1:0], 1'b1};
      w_qm_upd = {w_q_base[unrolling-1:0], 1'b0};
    end else if (w_minus) begin
      w_q_upd  = {w_qm_base[unrolling-1:0], 1'b1};
      w_qm_upd = {w_qm_base[unrolling-1:0], 1'b0};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_collect   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (online_delay == 0) begin
            w_collect   = 1'b1;
            w_state_nxt = (unrolling == 1) ? S_DONE : S_COLLECT;
          end else if (online_delay == 1) begin
            w_state_nxt = S_COLLECT;
          end else begin
            w_state_nxt = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (!enable_all) begin
          w_state_nxt = S_IDLE;
        end else if (w_cyc == LAST_SKIP) begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (!enable_all) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_collect = 1'b1;
          if (w_cyc == LAST_COLL) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      r_state   <= S_IDLE;
      r_en_prev <= 1'b0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_qm      <= '0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_en_prev <= enable_all;
      r_valid   <= (w_state_nxt == S_DONE);
      r_busy    <= (w_state_nxt == S_SKIP) || (w_state_nxt == S_COLLECT);

      if (w_start) begin
        r_cnt <= '0;
      end else if ((r_state == S_SKIP) || (r_state == S_COLLECT)) begin
        r_cnt <= w_cyc;
      end

      if (w_collect) begin
        r_q   <= w_q_upd;
        r_qm  <= w_qm_upd;
        r_err <= (r_err && !w_start) || w_inv;
      end else if (w_start) begin
        r_q   <= '0;
        r_qm  <= '1;
        r_err <= 1'b0;
      end
    end
  end

  // The final digit's update is captured directly so result is visible in the DONE cycle.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      r_result <= '0;
    end else if (w_state_nxt == S_DONE) begin
      r_result <= w_q_upd;
    end
  end

`ifdef OTF_QM_OUT_EN
  logic [unrolling:0] r_result_qm;

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      r_result_qm <= '0;
    end else if (w_state_nxt == S_DONE) begin
      r_result_qm <= w_qm_upd;
    end
  end

  assign result_qm = r_result_qm;
`endif

  assign result       = r_result;
  assign result_valid = r_valid;
  assign busy         = r_busy;
  assign digit_err    = r_err;

endmodule

// File: doc/sd_otf_converter.md
# sd_otf_converter

Receiving end of the online signed-digit stream. The block takes the MSD-first radix-2 signed-digit quotient stream that `Divider_v2` emits on `q_value` and turns it into a parallel two's-complement word using on-the-fly conversion (Q/QM registers). It discards the leading online-delay digits and needs no carry-propagate adder. It sits between the divider output and any conventional binary consumer.

## Interface
- `unrolling`, 64: number of digits collected per frame; the result is `unrolling+1` bits wide.
- `online_delay`, 3: number of leading digits discarded after frame start (0 allowed).
- `CNT_WIDTH`, 11: width of the cycle counter; must satisfy 2^CNT_WIDTH > `online_delay` + `unrolling`.

Ports:
- `clk`, input, 1: the block's only clock.
- `asyn_reset`, input, 1: reset, asynchronous and active-low.
- `enable_all`, input, 1: frame enable; a rising edge starts a frame, and low aborts any frame in progress.
- `q_value`, input, 2: signed digit. Bit[1] is plus, bit[0] is minus: 10 = +1, 01 = −1, 00 = 0, 11 = invalid (treated as 0).
- `result`, output, `unrolling+1`: two's-complement value of the collected digits × 2^unrolling.
- `result_valid`, output, 1: one-cycle pulse when `result` updates.
- `busy`, output, 1: high in the SKIP and COLLECT states.
- `digit_err`, output, 1: sticky per frame; set if any collected digit is 11.
- `result_qm`, output, `unrolling+1`: present only with `OTF_QM_OUT_EN`; equals `result` − 1.

## Operation
- **States**
  - IDLE → SKIP, or → COLLECT directly when `online_delay` = 0, on a start cycle: `enable_all` = 1 while the registered previous `enable_all` = 0.
  - SKIP → COLLECT after `online_delay` cycles.
  - COLLECT → DONE after `unrolling` digits.
  - DONE → IDLE unconditionally after 1 cycle.
- **Start cycle**
  - The start cycle counts as SKIP cycle 0, or as COLLECT digit 0 when the delay is 0.
  - On the start cycle, Q is loaded to all-zeros, QM to all-ones, `cnt` to 0, and `digit_err` is cleared.
- **Update rule** (n = `unrolling`; shifts are into the LSB), applied to each COLLECT digit:
  - +1: Q ← {Q[n−1:0], 1}, QM ← {Q[n−1:0], 0}.
  - 0 or 11: Q ← {Q[n−1:0], 0}, QM ← {QM[n−1:0], 1}.
  - −1: Q ← {QM[n−1:0], 1}, QM ← {QM[n−1:0], 0}.
- **Width rule:** the digit value lies in (−1, 1), so value × 2^n always fits in n+1 signed bits. No overflow is possible and none is flagged.
- **DONE cycle**
  - `result` ← Q and `result_qm` ← QM.
  - `result_valid` = 1 for exactly this one cycle.
  - `result` holds its value until the next DONE.
- **Abort:** `enable_all` = 0 during SKIP or COLLECT returns the block to IDLE the next cycle. There is no `result_valid`, `result` is unchanged, and `digit_err` holds its value.
- **Idle behaviour:**
  - Digits arriving in IDLE or DONE are ignored.
  - `enable_all` staying high after DONE does not restart the block; a new rising edge is required.
- **Async reset** (`asyn_reset` = 0), at any time including mid-frame:
  - State → IDLE.
  - Q, QM and `cnt` → 0.
  - `result`, `result_qm`, `result_valid`, `busy` and `digit_err` → 0.
  - The registered previous `enable_all` → 0, so `enable_all` high at reset release counts as a rising edge.

## Timing
- Let cycle 0 be the start cycle.
  - Digits sampled in cycles 0 … `online_delay`−1 are discarded.
  - Digits in cycles `online_delay` … `online_delay`+`unrolling`−1 are collected, MSD first.
  - `result_valid` is high in cycle `online_delay`+`unrolling`.
- Total latency from the start cycle to `result_valid` is `online_delay`+`unrolling` cycles.
- `busy` is registered: high from cycle 1 through cycle `online_delay`+`unrolling`−1 … and low from the `result_valid` cycle onward.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `OTF_QM_OUT_EN`
  - Defined: the `result_qm` port and its output register exist, exposing QM for the downstream rounding logic.
  - Undefined: the port is absent and QM is kept only internally. `result` behaviour is identical in both cases.

## Test plan
All scenarios use `unrolling` = 8 and `online_delay` = 3, so `result` is 9 bits.
- **First collected digit +1:** three skip digits of 01, then +1 followed by seven 0 digits → `result_valid` at cycle 11, `result` = 9'h080, `result_qm` = 9'h07F, `digit_err` = 0.
- **All −1:** eight −1 digits → `result` = 9'h101 (−255).
- **Mixed digits:** +1, −1, 0, 0, 0, 0, 0, 0 → `result` = 9'h040 (0.25 × 256). Digits −1, +1, then zeros → 9'h1C0 (−64).
- **Invalid code:** a frame containing one 11 digit among zeros → `result` = 9'h000, `digit_err` = 1. The next start clears `digit_err`.
- **Abort:**
  - Drop `enable_all` in COLLECT cycle 6 → no `result_valid`, the previous `result` is retained, `busy` = 0 the next cycle.
  - A new rising edge then gives a correct frame.
- **Reset mid-frame:** assert `asyn_reset` = 0 mid-COLLECT (between clock edges) → all outputs 0 immediately. Holding `enable_all` high through reset release starts a new frame.
